mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the state and owner encodings, the starvation limit and size codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] STARVE_LIMIT = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_buf_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port.
// One transaction in flight; data has priority unless fetch is starved.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  state_e     r_state;
  owner_e     r_owner;
  logic [1:0] r_starve;
  logic       r_drop;
  req_buf_t   r_buf;

  logic w_idle;
  logic w_inst_vld;
  logic w_inst_win;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_ack;
  logic w_inst_own;
  logic w_drop;

  assign w_idle     = rst & (r_state == S_IDLE);
  assign w_inst_vld = inst_req & ~inst_cancel;
  assign w_inst_win = w_inst_vld &
                      (~data_req | (r_starve == STARVE_LIMIT));
  assign w_gnt_i    = w_idle & w_inst_win;
  assign w_gnt_d    = w_idle & data_req & ~w_inst_win;
  assign w_ack      = rst & (r_state == S_DATA) & mem_data_ok;
  assign w_inst_own = (r_owner == OWN_INST);
  // A cancel in the completion cycle itself also drops the result.
  assign w_drop     = r_drop | inst_cancel;

  assign inst_addr_ok = w_gnt_i;
  assign data_addr_ok = w_gnt_d;
  assign inst_data_ok = w_ack & w_inst_own & ~w_drop;
  assign data_data_ok = w_ack & ~w_inst_own;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

  assign mem_req   = rst & (r_state == S_ADDR);
  assign mem_wr    = rst & r_buf.wr;
  assign mem_size  = rst ? r_buf.size  : 2'd0;
  assign mem_addr  = rst ? r_buf.addr  : 32'h0;
  assign mem_wdata = rst ? r_buf.wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_DATA;
      r_starve <= 2'd0;
      r_drop   <= 1'b0;
      r_buf    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_i) begin
            r_buf    <= '{1'b0, SIZE_WORD,
                          inst_addr, 32'h0};
            r_owner  <= OWN_INST;
            r_starve <= 2'd0;
            r_state  <= S_ADDR;
          end else if (w_gnt_d) begin
            r_buf    <= '{data_wr, data_size,
                          data_addr, data_wdata};
            r_owner  <= OWN_DATA;
            r_state  <= S_ADDR;
            if (inst_req && r_starve != STARVE_LIMIT)
              r_starve <= r_starve + 2'd1;
          end
        end
        S_ADDR: begin
          if (inst_cancel && w_inst_own)
            r_drop <= 1'b1;
          if (mem_addr_ok)
            r_state <= S_DATA;
        end
        S_DATA: begin
          if (mem_data_ok) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
          end else if (inst_cancel && w_inst_own) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks for mem_port_arbiter against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [159:0] obs,
                     input logic [159:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, want);
    end
  endtask

  function automatic logic [159:0] outs();
    return {24'h0, inst_addr_ok, inst_data_ok,
            data_addr_ok, data_data_ok, mem_req,
            mem_wr, mem_size, mem_addr, mem_wdata,
            inst_rdata, data_rdata};
  endfunction

  task automatic clr();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    inst_cancel = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // reference model state (transaction level)
  bit          m_busy;
  bit          m_acc;
  bit          m_own_d;
  bit          m_drop;
  int          m_starve;
  logic [66:0] m_fields;
  bit          e_ia, e_da, e_id, e_dd, e_mreq;
  bit          rel_i, rel_d;
  logic [4:0]  ord;

  initial begin
    rst = 1'b0;
    clr();

    // reset: everything low even with all inputs asserted
    inst_req    = 1'b1;
    data_req    = 1'b1;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #1 chk("rst_outs", outs(), '0);
    @(negedge clk);
    #1 chk("rst_outs2", outs(), '0);
    clr();
    rst = 1'b1;

    // fetch only
    @(negedge clk);
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00000;
    #1;
    chk("if_aok", {inst_addr_ok, data_addr_ok, mem_req},
        3'b100);
    @(negedge clk);
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    mem_addr_ok = 1'b1;
    #1;
    chk("if_mreq", {mem_req, inst_data_ok, inst_addr_ok},
        3'b100);
    chk("if_mfld", {mem_wr, mem_size, mem_addr},
        {1'b0, 2'd2, 32'hBFC00000});
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h24080001;
    #1;
    chk("if_dok", {inst_data_ok, data_data_ok, mem_req},
        3'b100);
    chk("if_rdata", inst_rdata, 32'h24080001);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1 chk("if_quiet", {inst_data_ok, inst_addr_ok}, 2'b00);

    // contention: data x3, inst, data
    do_reset();
    ord = 5'b10111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      inst_req    = 1'b1;
      inst_addr   = 32'h1000 + k;
      data_req    = 1'b1;
      data_addr   = 32'h2000 + k;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      #1;
      chk("cont_gnt", {inst_addr_ok, data_addr_ok},
          ord[k] ? 2'b01 : 2'b10);
      @(negedge clk);
      mem_addr_ok = 1'b1;
      #1;
      chk("cont_busy", {inst_addr_ok, data_addr_ok, mem_req},
          3'b001);
      chk("cont_addr", mem_addr,
          ord[k] ? 32'h2000 + k : 32'h1000 + k);
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hC0DE0000 + k;
      #1;
      chk("cont_dok", {inst_data_ok, data_data_ok},
          ord[k] ? 2'b01 : 2'b10);
    end

    // store held through an address stall
    do_reset();
    @(negedge clk);
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd0;
    data_addr  = 32'h80000003;
    data_wdata = 32'h000000AB;
    #1 chk("st_aok", {data_addr_ok, inst_addr_ok}, 2'b10);
    @(negedge clk);
    clr();
    data_addr = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      mem_addr_ok = (k == 3);
      #1;
      chk("st_fld", {mem_req, mem_wr, mem_size,
                     mem_addr, mem_wdata},
          {1'b1, 1'b1, 2'd0, 32'h80000003, 32'hAB});
      chk("st_nodok", data_data_ok, 1'b0);
    end
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5A5A5A5A;
    #1;
    chk("st_dok", {data_data_ok, mem_req}, 2'b10);

    // cancel: no grant with cancel in idle, drop in data
    do_reset();
    @(negedge clk);
    inst_req    = 1'b1;
    inst_addr   = 32'h00400000;
    inst_cancel = 1'b1;
    #1 chk("cn_idle", inst_addr_ok, 1'b0);
    @(negedge clk);
    inst_cancel = 1'b0;
    #1 chk("cn_gnt", inst_addr_ok, 1'b1);
    @(negedge clk);
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    #1 chk("cn_mreq", mem_req, 1'b1);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    inst_cancel = 1'b1;
    #1 chk("cn_wait", inst_data_ok, 1'b0);
    @(negedge clk);
    inst_cancel = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h11111111;
    #1 chk("cn_drop", {inst_data_ok, mem_req}, 2'b00);
    @(negedge clk);
    mem_data_ok = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h00400004;
    #1 chk("cn_regnt", inst_addr_ok, 1'b1);
    @(negedge clk);
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    #1 chk("cn_addr2", mem_addr, 32'h00400004);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h22222222;
    #1;
    chk("cn_dok2", inst_data_ok, 1'b1);
    chk("cn_rd2", inst_rdata, 32'h22222222);

    // reset while waiting for data
    do_reset();
    @(negedge clk);
    data_req  = 1'b1;
    data_addr = 32'h12345678;
    #1 chk("rm_gnt", data_addr_ok, 1'b1);
    @(negedge clk);
    data_req    = 1'b0;
    mem_addr_ok = 1'b1;
    #1 chk("rm_mreq", mem_req, 1'b1);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    rst         = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h33333333;
    #1 chk("rm_outs", outs(), '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rm_late", {inst_data_ok, data_data_ok, mem_req},
        3'b000);
    @(negedge clk);
    mem_data_ok = 1'b0;
    data_req    = 1'b1;
    #1 chk("rm_idle", data_addr_ok, 1'b1);

    // randomized traffic against the reference model
    do_reset();
    m_busy   = 0;
    m_acc    = 0;
    m_drop   = 0;
    m_own_d  = 0;
    m_starve = 0;
    rel_i    = 0;
    rel_d    = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (rel_i) inst_req = 1'b0;
      if (rel_d) data_req = 1'b0;
      rel_i = 0;
      rel_d = 0;
      if (!inst_req && $urandom_range(2) == 0) begin
        inst_req  = 1'b1;
        inst_addr = $urandom;
      end
      if (!data_req && $urandom_range(2) == 0) begin
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(1));
        data_size  = 2'($urandom_range(2));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      inst_cancel = ($urandom_range(7) == 0);
      mem_addr_ok = 1'($urandom_range(1));
      mem_data_ok = ($urandom_range(2) == 0);
      mem_rdata   = $urandom;
      #1;
      {e_ia, e_da, e_id, e_dd, e_mreq} = '0;
      if (!m_busy) begin
        if (inst_req && !inst_cancel &&
            (!data_req || m_starve >= 3))
          e_ia = 1;
        else if (data_req)
          e_da = 1;
      end else if (!m_acc) begin
        e_mreq = 1;
      end else if (mem_data_ok) begin
        if (m_own_d) e_dd = 1;
        else if (!(m_drop || inst_cancel)) e_id = 1;
      end
      chk("rnd_aok", {inst_addr_ok, data_addr_ok},
          {e_ia, e_da});
      chk("rnd_dok", {inst_data_ok, data_data_ok},
          {e_id, e_dd});
      chk("rnd_mreq", mem_req, e_mreq);
      if (e_mreq && m_own_d)
        chk("rnd_dfld", {mem_wr, mem_size, mem_addr,
                         mem_wdata}, m_fields);
      if (e_mreq && !m_own_d)
        chk("rnd_ifld", {mem_wr, mem_size, mem_addr},
            m_fields[66:32]);
      if (e_id) chk("rnd_ird", inst_rdata, mem_rdata);
      if (e_dd) chk("rnd_drd", data_rdata, mem_rdata);
      if (e_ia) begin
        m_busy   = 1;
        m_own_d  = 0;
        m_fields = {1'b0, 2'd2, inst_addr, 32'h0};
        m_starve = 0;
        rel_i    = 1;
      end else if (e_da) begin
        m_busy   = 1;
        m_own_d  = 1;
        m_fields = {data_wr, data_size, data_addr,
                    data_wdata};
        if (inst_req && m_starve < 3) m_starve++;
        rel_d = 1;
      end else if (m_busy) begin
        if (!m_own_d && inst_cancel) m_drop = 1;
        if (!m_acc) begin
          if (mem_addr_ok) m_acc = 1;
        end else if (mem_data_ok) begin
          m_busy = 0;
          m_acc  = 0;
          m_drop = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
